lsu_mem_ctrl: RTL

- Load/store initiator between the core datapath and the word-addressed data memory. The memory offers only combinational word reads and whole-word synchronous writes.
- Accepts byte/halfword/word loads and stores over a valid/ready request port, checks alignment and range, and drives the memory's read/write strobes.
- Sub-word stores use a two-step read-modify-write. Loads return sign- or zero-extended data.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_mem_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store memory controller.
// Extract/merge are pure combinational functions used directly by the FSM.
package lsu_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} mem_size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  offset,
                                                 input mem_size_e   size,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    return {{24{b[7] & ~uns}}, b};
            SZ_H:    return {{16{h[15] & ~uns}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  offset,
                                               input mem_size_e   size);
        logic [31:0] m;
        m = old;
        case (size)
            SZ_B:    m[{offset, 3'b000} +: 8] = wdata[7:0];
            SZ_H:    m[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: m = wdata;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: validates requests, drives word-memory strobes,
// and performs read-modify-write for byte/halfword stores.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state;
    logic        we_q;
    logic        uns_q;
    mem_size_e   size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    mem_size_e   req_sz;
    logic        accept;
    logic        bad_align;
    logic        bad_range;
    logic        req_err;
    logic        mem_active;

    assign req_sz = mem_size_e'(req_size);
    assign accept = req_valid && req_ready;

    always_comb begin
        bad_align = 1'b0;
        case (req_sz)
            SZ_H:    bad_align = req_addr[0];
            SZ_W:    bad_align = |req_addr[1:0];
            SZ_X:    bad_align = 1'b1;
            default: bad_align = 1'b0;
        endcase
    end

    // Address bits above the memory's byte span are either an error or ignored.
    generate
        if (CHECK_RANGE && (DEPTH_LOG2 < 30)) begin : g_range
            assign bad_range = |req_addr[31:DEPTH_LOG2+2];
        end else begin : g_no_range
            assign bad_range = 1'b0;
        end
    endgenerate

    assign req_err = bad_align | bad_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        size_q  <= req_sz;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rdata_q <= 32'h0;
                        err_q   <= req_err;
                        if (req_err)
                            state <= ST_RESP;
                        else if (!req_we)
                            state <= ST_LOAD;
                        else if (req_sz == SZ_W)
                            state <= ST_WRITE;
                        else
                            state <= ST_RMW_RD;
                    end
                end
                ST_LOAD: begin
                    rdata_q <= lane_extract(mem_rdata, addr_q[1:0], size_q, uns_q);
                    state   <= ST_RESP;
                end
                ST_RMW_RD: begin
                    // Latched store data is replaced by the merged word for WRITE.
                    wdata_q <= lane_merge(mem_rdata, wdata_q, addr_q[1:0], size_q);
                    state   <= ST_WRITE;
                end
                ST_WRITE: state <= ST_RESP;
                ST_RESP:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = (resp_valid && !we_q) ? rdata_q : 32'h0;
    assign resp_err   = resp_valid && err_q;

    assign mem_active = (state == ST_LOAD) || (state == ST_RMW_RD) || (state == ST_WRITE);
    assign mem_read   = (state == ST_LOAD) || (state == ST_RMW_RD);
    // Gated by rst so the strobe drops the instant reset rises, not after state settles.
    assign mem_write  = (state == ST_WRITE) && !rst;
    assign mem_addr   = mem_active ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wdata  = (state == ST_WRITE) ? wdata_q : 32'h0;

endmodule
